// File: rtl/verdict_pkg.sv
// Shared configuration, record layout and FSM encoding for the verdict collector.
// The monitor configuration is fixed here so every file sees the same record shape.
package verdict_pkg;

    localparam int NUM_OUTPUTS  = 4;
    localparam int DATA_W       = 64;
    localparam int TS_W         = 32;
    localparam int FIFO_DEPTH   = 8;
    localparam int IDX_W        = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam int HDR_TS_LSB   = 0;
    localparam int HDR_MASK_LSB = TS_W;
    localparam int DROP_W       = 16;

    typedef struct packed {
        logic [TS_W-1:0]               ts;
        logic [NUM_OUTPUTS-1:0]        mask;
        logic [NUM_OUTPUTS*DATA_W-1:0] data;
    } rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Lowest set bit of m; returns 0 when m is empty.
    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_OUTPUTS-1:0] m);
        first_set = '0;
        for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
            if (m[i]) first_set = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/verdict_collector_sync_fifo.sv
// Single-clock FIFO with registered occupancy; read data is the head entry, valid in
// the same cycle the pop is issued. DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/verdict_collector.sv
// Captures active monitor output cycles as timestamped records and serializes them
// as header + value beats on a valid/ready stream, counting records lost to a full FIFO.
module verdict_collector
    import verdict_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
    input  logic [NUM_OUTPUTS-1:0]        out_aktv,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [DATA_W-1:0]             rec_word,
    output logic                          rec_hdr,
    output logic [IDX_W-1:0]              rec_idx,
    output logic                          rec_last,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          overflow
);

    // Stream handshake: a beat transfers on a rising edge where rec_valid && rec_ready.
    // Once rec_valid rises, the beat fields hold until that transfer (only rst cancels it).

    state_e             state_q, state_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               ovf_q, ovf_d;
    rec_t               rec_q, rec_d;
    logic [NUM_OUTPUTS-1:0] rem_q, rem_d;

    rec_t               cap_rec;
    rec_t               fifo_rd;
    logic               fifo_full, fifo_empty;
    logic               cap_req, push, pop;

    logic [IDX_W-1:0]       cur_idx;
    logic [NUM_OUTPUTS-1:0] cur_bit;
    logic                   cur_last;

    assign cap_rec = '{ts: ts_q, mask: out_aktv, data: out_data};

    sync_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (cap_rec),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Capture, timestamp and drop accounting; a same-cycle pop never frees room.
    always_comb begin
        cap_req = en && (|out_aktv);
        push    = cap_req && !fifo_full;
        ts_d    = en ? ts_q + 1'b1 : ts_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        if (cap_req && fifo_full) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 1'b1;
        end
    end

    // rem_q holds the mask bits still to be sent for the current record.
    always_comb begin
        cur_idx          = first_set(rem_q);
        cur_bit          = '0;
        cur_bit[cur_idx] = 1'b1;
        cur_last         = ((rem_q & ~cur_bit) == '0);
    end

    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) pop = 1'b1;
            end
            ST_HDR: begin
                if (rec_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (rec_ready) begin
                    rem_d = rem_q & ~cur_bit;
                    if (cur_last) begin
                        state_d = ST_IDLE;
                        if (!fifo_empty) pop = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Popping straight into HDR gives back-to-back records with no idle bubble.
        if (pop) begin
            rec_d   = fifo_rd;
            rem_d   = fifo_rd.mask;
            state_d = ST_HDR;
        end
    end

    always_comb begin
        rec_valid = (state_q != ST_IDLE);
        rec_hdr   = (state_q == ST_HDR);
        rec_idx   = '0;
        rec_last  = 1'b0;
        rec_word  = '0;
        case (state_q)
            ST_HDR: begin
                rec_word[HDR_TS_LSB +: TS_W]          = rec_q.ts;
                rec_word[HDR_MASK_LSB +: NUM_OUTPUTS] = rec_q.mask;
            end
            ST_DATA: begin
                rec_idx  = cur_idx;
                rec_last = cur_last;
                rec_word = rec_q.data[int'(cur_idx)*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    assign drop_count = drop_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            rec_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            rec_q   <= rec_d;
            rem_q   <= rem_d;
        end
    end

endmodule
